// File: rtl/buffer_w_ctrl.sv
// buffer_w_ctrl: controller for a single-bank ping buffer.
// Each upstream beat is written as TOTAL_MODULES consecutive slices.
// A full fill is followed by READ_PASSES sweeps of the whole buffer,
// with a valid/ready handshake and a read latency of one cycle.
// The RAM itself lives outside this block; only its port controls are driven here.
module buffer_w_ctrl #(
    parameter int TOTAL_MODULES = 4,
    parameter int NUM_WR_BEATS  = 8,
    parameter int READ_PASSES   = 1,
    localparam int NUM_ENTRIES  = NUM_WR_BEATS * TOTAL_MODULES,
    localparam int ADDR_WIDTH   = $clog2(NUM_ENTRIES),
    localparam int SLICE_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SLICE_W-1:0]    slicing_idx,
    output logic                  bank0_ena,
    output logic                  bank0_wea,
    output logic [ADDR_WIDTH-1:0] bank0_addra,
    output logic                  bank0_enb,
    output logic [ADDR_WIDTH-1:0] bank0_addrb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    // Job phases
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Total number of reads (and accepts) that make up one drain
    localparam int TOTAL_READS = NUM_ENTRIES * READ_PASSES;
    localparam int CNT_W       = $clog2(TOTAL_READS + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [SLICE_W-1:0]    LAST_SLICE = SLICE_W'(TOTAL_MODULES - 1);
    localparam logic [CNT_W-1:0]      TOTAL_CNT  = CNT_W'(TOTAL_READS);
    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(TOTAL_READS - 1);

    // State and counters
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_addra;
    logic [SLICE_W-1:0]    r_slice;
    logic [ADDR_WIDTH-1:0] r_addrb;
    logic [CNT_W-1:0]      r_rd_issued;
    logic [CNT_W-1:0]      r_rd_accepted;
    logic                  r_out_valid;

    // Per-cycle events
    logic w_start;
    logic w_write;
    logic w_last_write;
    logic w_reads_left;
    logic w_read;
    logic w_accept;
    logic w_last_accept;

    // A start is only honoured while idle; it also clears all job counters
    assign w_start = (r_state == S_IDLE) && start;

    // One slice is written every cycle upstream data is present during FILL
    assign w_write      = (r_state == S_FILL) && in_valid;
    assign w_last_write = w_write && (r_addra == LAST_ADDR);

    // A read may be issued when the output register is empty or being emptied
    assign w_reads_left  = (r_rd_issued != TOTAL_CNT);
    assign w_read        = (r_state == S_DRAIN) && (!r_out_valid || out_ready) && w_reads_left;
    assign w_accept      = (r_state == S_DRAIN) && r_out_valid && out_ready;
    assign w_last_accept = w_accept && (r_rd_accepted == LAST_CNT);

    // Next-state selection for the job sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)         w_state_next = S_FILL;
            S_FILL:  if (w_last_write)  w_state_next = S_DRAIN;
            S_DRAIN: if (w_last_accept) w_state_next = S_DONE;
            S_DONE:                     w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any job in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write address and slice index advance together on every issued write
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_addra <= '0;
            r_slice <= '0;
        end else if (w_write) begin
            r_addra <= (r_addra == LAST_ADDR)  ? '0 : r_addra + ADDR_WIDTH'(1);
            r_slice <= (r_slice == LAST_SLICE) ? '0 : r_slice + SLICE_W'(1);
        end
    end

    // Read address sweeps the buffer and wraps for each pass; count issued reads
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_addrb     <= '0;
            r_rd_issued <= '0;
        end else if (w_read) begin
            r_addrb     <= (r_addrb == LAST_ADDR) ? '0 : r_addrb + ADDR_WIDTH'(1);
            r_rd_issued <= r_rd_issued + CNT_W'(1);
        end
    end

    // Count entries handed downstream; the last one ends the drain
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_rd_accepted <= '0;
        end else if (w_accept) begin
            r_rd_accepted <= r_rd_accepted + CNT_W'(1);
        end
    end

    // Output valid follows the RAM read latency and drops after an accept without refill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (r_state != S_DRAIN) begin
            r_out_valid <= 1'b0;
        end else if (w_read) begin
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = w_write && (r_slice == LAST_SLICE);
    assign slicing_idx = r_slice;
    assign bank0_ena   = w_write;
    assign bank0_wea   = w_write;
    assign bank0_addra = r_addra;
    assign bank0_enb   = w_read;
    assign bank0_addrb = r_addrb;
    assign out_valid   = r_out_valid;
    assign busy        = (r_state == S_FILL) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_buffer_w_ctrl.sv
// Directed bench for buffer_w_ctrl: two instances (one and two read passes),
// each backed by a small behavioural RAM so delivered data can be checked.
module tb_buffer_w_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: 4 slices x 2 beats, one read pass
    logic       a_start, a_in_valid, a_in_ready, a_ena, a_wea, a_enb;
    logic       a_out_valid, a_out_ready, a_busy, a_done;
    logic [1:0] a_slice;
    logic [2:0] a_addra, a_addrb;
    logic [7:0] a_din, a_dout;
    logic [7:0] a_ram [0:7];

    // Instance B: 4 slices x 2 beats, two read passes
    logic       b_start, b_in_valid, b_in_ready, b_ena, b_wea, b_enb;
    logic       b_out_valid, b_out_ready, b_busy, b_done;
    logic [1:0] b_slice;
    logic [2:0] b_addra, b_addrb;
    logic [7:0] b_din, b_dout;
    logic [7:0] b_ram [0:7];

    int total = 0;
    int bad   = 0;
    int a_acc_cnt = 0, a_done_cnt = 0, b_acc_cnt = 0, b_done_cnt = 0;
    int acc0, done0;

    buffer_w_ctrl #(.TOTAL_MODULES(4), .NUM_WR_BEATS(2), .READ_PASSES(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .slicing_idx(a_slice), .bank0_ena(a_ena), .bank0_wea(a_wea), .bank0_addra(a_addra),
        .bank0_enb(a_enb), .bank0_addrb(a_addrb), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy), .done(a_done)
    );

    buffer_w_ctrl #(.TOTAL_MODULES(4), .NUM_WR_BEATS(2), .READ_PASSES(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .slicing_idx(b_slice), .bank0_ena(b_ena), .bank0_wea(b_wea), .bank0_addra(b_addra),
        .bank0_enb(b_enb), .bank0_addrb(b_addrb), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy), .done(b_done)
    );

    // Behavioural RAMs with one-cycle read latency; dout holds when not read
    always @(posedge clk) begin
        if (a_ena && a_wea) a_ram[a_addra] <= a_din;
        if (a_enb) a_dout <= a_ram[a_addrb];
        if (b_ena && b_wea) b_ram[b_addra] <= b_din;
        if (b_enb) b_dout <= b_ram[b_addrb];
    end

    // Handshake and done-pulse counters
    always @(posedge clk) begin
        if (a_out_valid && a_out_ready) a_acc_cnt <= a_acc_cnt + 1;
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_out_valid && b_out_ready) b_acc_cnt <= b_acc_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[%0t] check %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 0; a_in_valid = 0; a_out_ready = 0; a_din = 0;
        b_start = 0; b_in_valid = 0; b_out_ready = 0; b_din = 0;
        tick();
        tick();
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ena", a_ena, 0);
        chk("rst_enb", a_enb, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_addra", a_addra, 0);
        chk("rst_addrb", a_addrb, 0);
        chk("rst_slice", a_slice, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;
        tick();

        // ---- Job 1 on A: fill with a 3-cycle gap, drain with a 4-cycle stall ----
        a_start = 1;
        #1;
        chk("idle_busy", a_busy, 0);
        tick();
        a_start = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                a_in_valid = 0;
                for (int g = 0; g < 3; g++) begin
                    a_start = (g == 1);
                    #1;
                    chk("gap_ena", a_ena, 0);
                    chk("gap_addra", a_addra, 2);
                    chk("gap_slice", a_slice, 2);
                    chk("gap_in_ready", a_in_ready, 0);
                    chk("gap_busy", a_busy, 1);
                    tick();
                end
                a_start = 0;
            end
            a_in_valid = 1;
            a_din = 8'hA0 + 8'(k);
            #1;
            chk("fill_ena", a_ena, 1);
            chk("fill_wea", a_wea, 1);
            chk("fill_addra", a_addra, k);
            chk("fill_slice", a_slice, k % 4);
            chk("fill_in_ready", a_in_ready, (k % 4) == 3);
            chk("fill_enb", a_enb, 0);
            tick();
        end
        a_in_valid = 0;
        a_out_ready = 1;
        acc0 = a_acc_cnt;
        done0 = a_done_cnt;
        for (int d = 0; d < 4; d++) begin
            #1;
            chk("drain_busy", a_busy, 1);
            chk("drain_ena", a_ena, 0);
            chk("drain_enb", a_enb, 1);
            chk("drain_addrb", a_addrb, d);
            chk("drain_out_valid", a_out_valid, d > 0);
            if (d > 0) chk("drain_dout", a_dout, 8'hA0 + d - 1);
            tick();
        end
        a_out_ready = 0;
        for (int s = 0; s < 4; s++) begin
            a_start = (s == 0);
            #1;
            chk("stall_out_valid", a_out_valid, 1);
            chk("stall_enb", a_enb, 0);
            chk("stall_dout", a_dout, 8'hA3);
            chk("stall_addrb", a_addrb, 4);
            tick();
        end
        a_start = 0;
        a_out_ready = 1;
        for (int j = 4; j < 8; j++) begin
            #1;
            chk("resume_out_valid", a_out_valid, 1);
            chk("resume_dout", a_dout, 8'hA0 + j - 1);
            chk("resume_enb", a_enb, 1);
            chk("resume_addrb", a_addrb, j);
            tick();
        end
        #1;
        chk("last_out_valid", a_out_valid, 1);
        chk("last_dout", a_dout, 8'hA7);
        chk("last_enb", a_enb, 0);
        chk("last_done", a_done, 0);
        tick();
        #1;
        chk("done_pulse", a_done, 1);
        chk("done_busy", a_busy, 0);
        chk("done_out_valid", a_out_valid, 0);
        chk("accepts_job1", a_acc_cnt - acc0, 8);
        tick();
        #1;
        chk("done_cleared", a_done, 0);
        chk("done_count_job1", a_done_cnt - done0, 1);
        chk("idle_after_job1", a_busy, 0);

        // ---- Job 2 on A: reset at write 5, then restart and complete ----
        done0 = a_done_cnt;
        a_start = 1;
        tick();
        a_start = 0;
        a_in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            a_din = 8'hB0 + 8'(k);
            #1;
            chk("abort_fill_addra", a_addra, k);
            tick();
        end
        rst = 1;
        #1;
        chk("abort_write5_addra", a_addra, 5);
        tick();
        rst = 0;
        #1;
        chk("abort_busy", a_busy, 0);
        chk("abort_ena", a_ena, 0);
        chk("abort_addra", a_addra, 0);
        chk("abort_slice", a_slice, 0);
        a_start = 1;
        tick();
        a_start = 0;
        for (int k = 0; k < 8; k++) begin
            a_din = 8'hC0 + 8'(k);
            #1;
            chk("restart_addra", a_addra, k);
            chk("restart_slice", a_slice, k % 4);
            if (k == 0) chk("restart_ena", a_ena, 1);
            tick();
        end
        a_in_valid = 0;
        chk("abort_no_done", a_done_cnt - done0, 0);
        for (int d = 0; d < 9; d++) begin
            #1;
            chk("job2_enb", a_enb, d < 8);
            if (d < 8) chk("job2_addrb", a_addrb, d);
            if (d > 0) chk("job2_dout", a_dout, 8'hC0 + d - 1);
            tick();
        end
        #1;
        chk("job2_done", a_done, 1);
        tick();
        #1;
        chk("job2_done_count", a_done_cnt - done0, 1);

        // ---- Job 3 on B: two read passes ----
        acc0 = b_acc_cnt;
        done0 = b_done_cnt;
        b_start = 1;
        tick();
        b_start = 0;
        b_in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            b_din = 8'hD0 + 8'(k);
            #1;
            chk("b_fill_addra", b_addra, k);
            chk("b_fill_in_ready", b_in_ready, (k % 4) == 3);
            tick();
        end
        b_in_valid = 0;
        b_out_ready = 1;
        for (int d = 0; d < 17; d++) begin
            #1;
            chk("b_enb", b_enb, d < 16);
            if (d < 16) chk("b_addrb", b_addrb, d % 8);
            chk("b_out_valid", b_out_valid, d > 0);
            if (d > 0) chk("b_dout", b_dout, 8'hD0 + ((d - 1) % 8));
            chk("b_done_early", b_done, 0);
            tick();
        end
        #1;
        chk("b_done", b_done, 1);
        chk("b_accepts", b_acc_cnt - acc0, 16);
        tick();
        #1;
        chk("b_done_cleared", b_done, 0);
        chk("b_done_count", b_done_cnt - done0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_w_ctrl.md
BUFFER_W_CTRL -- requirements
Module: buffer_w_ctrl

Interface
REQ-001 SHALL have parameter TOTAL_MODULES, default 4, meaning the number of module slices per input beat.
REQ-002 SHALL have parameter NUM_WR_BEATS, default 8, meaning the number of input beats per fill.
REQ-003 SHALL have parameter READ_PASSES, default 1, meaning the number of full read sweeps per fill.
REQ-004 SHALL have localparam NUM_ENTRIES = NUM_WR_BEATS*TOTAL_MODULES and ADDR_WIDTH = $clog2(NUM_ENTRIES), with NUM_ENTRIES at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle request to begin a fill/drain job, sampled only in IDLE.
REQ-008 SHALL have port in_valid, input, 1 bit: the upstream projection beat is present on the buffer's din.
REQ-009 SHALL have port in_ready, output, 1 bit: the current beat is consumed this cycle.
REQ-010 SHALL have port slicing_idx, output, $clog2(TOTAL_MODULES) bits: the module slice selected for write.
REQ-011 SHALL have ports bank0_ena, bank0_wea, bank0_addra (ADDR_WIDTH bits), all outputs: write port controls.
REQ-012 SHALL have ports bank0_enb and bank0_addrb (ADDR_WIDTH bits), both outputs: read port controls.
REQ-013 SHALL have port out_valid, output, 1 bit: bank0_dout holds a valid entry.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts bank0_dout.
REQ-015 SHALL have ports busy and done, both outputs, 1 bit each: busy means a job is active; done is a one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, FILL, DRAIN and DONE.
- IDLE to FILL: on start.
- FILL to DRAIN: on the cycle the last write (address NUM_ENTRIES-1) is issued.
- DRAIN to DONE: when the final entry of the final pass is accepted.
- DONE to IDLE: unconditionally after one cycle.
REQ-017 In FILL with in_valid=1, SHALL assert bank0_ena=bank0_wea=1 at bank0_addra, then increment addra and slicing_idx; slicing_idx wraps from TOTAL_MODULES-1 to 0.
REQ-018 In FILL with in_valid=0, SHALL assert no write and hold addra and slicing_idx.
REQ-019 SHALL assert in_ready = (state==FILL) && in_valid && (slicing_idx==TOTAL_MODULES-1), so one input beat spans TOTAL_MODULES write cycles.
REQ-020 In DRAIN, SHALL issue a read (enb=1) when (!out_valid || out_ready) and reads remain; otherwise enb=0, and bank0_dout is held by the RAM.
REQ-021 SHALL set out_valid one cycle after an issued read (read latency 1).
REQ-022 SHALL clear out_valid after an accept (out_valid && out_ready) in a cycle with no new read.
REQ-023 SHALL make addrb sweep 0..NUM_ENTRIES-1 and wrap to 0 for each of the READ_PASSES passes; the total reads issued equal NUM_ENTRIES*READ_PASSES.
REQ-024 SHALL never assert bank0_enb in FILL and never assert bank0_ena in DRAIN.
REQ-025 SHALL assert busy in FILL and DRAIN, and done only in DONE.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL hold out_valid, with dout unchanged, while out_ready=0.

Reset
REQ-028 With rst=1 at a clock edge, SHALL enter IDLE, with both addresses=0, slicing_idx=0, read counters=0, and all enables, in_ready, out_valid, busy and done=0.
REQ-029 A reset in any state, including mid-FILL or mid-DRAIN, SHALL abandon the job; the next job SHALL restart from address 0 after a new start.

Verification
REQ-030 With TOTAL_MODULES=4, NUM_WR_BEATS=2, and start then in_valid held high: writes go to addra 0..7 with slicing_idx 0,1,2,3,0,1,2,3; in_ready is high on cycles 4 and 8 of FILL; state is DRAIN on the next cycle.
REQ-031 Deassert in_valid for 3 cycles after the 2nd write: no ena pulses during the gap; the 3rd write uses addra=2 and slicing_idx=2.
REQ-032 DRAIN with out_ready=1: enb is high for 8 consecutive cycles with addrb 0..7; out_valid is high for 8 cycles lagging by 1; done pulses once, 1 cycle after the last accept.
REQ-033 out_ready=0 for 4 cycles mid-DRAIN at entry 3: out_valid stays high, no enb; entry 3 is delivered once, then entry 4 follows.
REQ-034 READ_PASSES=2: addrb goes 0..7,0..7; 16 accepts occur before done.
REQ-035 rst asserted at write 5, then start again: the first write after restart uses addra=0 and slicing_idx=0; no done from the aborted job.
